// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 size codes, FSM state encoding
// and the size/legality helpers used by the decoder.
package lsu_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_D  = 3'b011;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;
  localparam logic [2:0] LSU_WU = 3'b110;

  typedef enum logic [2:0] {
    LSU_IDLE  = 3'd0,
    LSU_REQ   = 3'd1,
    LSU_WAIT  = 3'd2,
    LSU_RESP  = 3'd3,
    LSU_REQ2  = 3'd4,
    LSU_WAIT2 = 3'd5
  } lsu_state_e;

  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    logic [3:0] n;
    case (funct3[1:0])
      2'b00:   n = 4'd1;
      2'b01:   n = 4'd2;
      2'b10:   n = 4'd4;
      default: n = 4'd8;
    endcase
    return n;
  endfunction

  // Doubleword and LWU only exist on a 64-bit datapath; stores have no unsigned forms.
  function automatic logic is_legal(input logic [2:0] funct3, input logic we, input int xlen);
    logic ok;
    logic wide;
    wide = (xlen == 64);
    if (we) begin
      ok = (funct3 == LSU_B) || (funct3 == LSU_H) || (funct3 == LSU_W) ||
           ((funct3 == LSU_D) && wide);
    end else begin
      case (funct3)
        LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU: ok = 1'b1;
        LSU_D, LSU_WU:                       ok = wide;
        default:                             ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store byte-enable/data shift and load shift/extend,
// both computed over a two-word window so boundary-crossing accesses fall out naturally.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]                  funct3,
  input  logic [$clog2(XLEN/8)-1:0]   off,
  input  logic [XLEN-1:0]             st_data,
  output logic [2*(XLEN/8)-1:0]       st_be,
  output logic [2*XLEN-1:0]           st_wdata,
  input  logic [2*XLEN-1:0]           ld_raw,
  output logic [XLEN-1:0]             ld_data
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  logic [2*NB-1:0]  size_mask;
  logic [OFF_W+2:0] bit_off;
  logic [XLEN-1:0]  ld_shift;

  assign bit_off = {off, 3'b000};

  always_comb begin
    case (size_bytes(funct3))
      4'd1:    size_mask = (2*NB)'(8'h01);
      4'd2:    size_mask = (2*NB)'(8'h03);
      4'd4:    size_mask = (2*NB)'(8'h0F);
      default: size_mask = (2*NB)'(8'hFF);
    endcase
  end

  assign st_be    = size_mask << off;
  assign st_wdata = {{XLEN{1'b0}}, st_data} << bit_off;

  // Upper window half carries the second beat of a split load; it is zero otherwise.
  assign ld_shift = XLEN'(ld_raw >> bit_off);

  always_comb begin
    ld_data = '0;
    case (funct3)
      LSU_B:   ld_data = XLEN'($signed(ld_shift[7:0]));
      LSU_BU:  ld_data = XLEN'(ld_shift[7:0]);
      LSU_H:   ld_data = XLEN'($signed(ld_shift[15:0]));
      LSU_HU:  ld_data = XLEN'(ld_shift[15:0]);
      LSU_W:   ld_data = XLEN'($signed(ld_shift[31:0]));
      LSU_WU:  ld_data = XLEN'(ld_shift[31:0]);
      default: ld_data = ld_shift;
    endcase
  end

endmodule

// File: rtl/lsu_mem_if.sv
// Handshaked multi-cycle load/store unit between execute and the data memory port.
// Optional build macro LSU_MISALIGNED_SPLIT_EN splits boundary-crossing accesses into two beats.
module lsu_mem_if
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_funct3,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [XLEN-1:0]      req_wdata,
  output logic                 rsp_valid,
  output logic [XLEN-1:0]      rsp_rdata,
  output logic                 rsp_err,
  output logic                 mem_req,
  input  logic                 mem_gnt,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [XLEN/8-1:0]    mem_be,
  output logic [XLEN-1:0]      mem_wdata,
  input  logic                 mem_rvalid,
  input  logic [XLEN-1:0]      mem_rdata,
  input  logic                 mem_err
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  localparam logic [2:0] ST_IDLE  = LSU_IDLE;
  localparam logic [2:0] ST_REQ   = LSU_REQ;
  localparam logic [2:0] ST_WAIT  = LSU_WAIT;
  localparam logic [2:0] ST_RESP  = LSU_RESP;
`ifdef LSU_MISALIGNED_SPLIT_EN
  localparam logic [2:0] ST_REQ2  = LSU_REQ2;
  localparam logic [2:0] ST_WAIT2 = LSU_WAIT2;
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  logic [2:0]        state;
  logic              out_en;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic              err_q;
  logic [XLEN-1:0]   rdata_q;
`ifdef LSU_MISALIGNED_SPLIT_EN
  logic              split_q;
  logic [XLEN-1:0]   beat1_q;
  logic              req_cross;
`endif

  logic              req_legal;
  logic              req_misal;
  logic [OFF_W-1:0]  size_m1;
  logic              second_beat;
  logic [ADDR_W-1:0] base_addr;
  logic [2*NB-1:0]   st_be;
  logic [2*XLEN-1:0] st_wdata;
  logic [2*XLEN-1:0] ld_raw;
  logic [XLEN-1:0]   ld_data;

  assign req_legal = is_legal(req_funct3, req_we, XLEN);
  assign size_m1   = OFF_W'(size_bytes(req_funct3) - 4'd1);
  assign req_misal = |(req_addr[OFF_W-1:0] & size_m1);

`ifdef LSU_MISALIGNED_SPLIT_EN
  assign req_cross   = (int'(req_addr[OFF_W-1:0]) + int'(size_bytes(req_funct3))) > NB;
  assign second_beat = (state == ST_REQ2) || (state == ST_WAIT2);
  assign mem_req     = (state == ST_REQ) || (state == ST_REQ2);
  assign ld_raw      = second_beat ? {mem_rdata, beat1_q} : {{XLEN{1'b0}}, mem_rdata};
`else
  assign second_beat = 1'b0;
  assign mem_req     = (state == ST_REQ);
  assign ld_raw      = {{XLEN{1'b0}}, mem_rdata};
`endif

  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .funct3   (f3_q),
    .off      (addr_q[OFF_W-1:0]),
    .st_data  (wdata_q),
    .st_be    (st_be),
    .st_wdata (st_wdata),
    .ld_raw   (ld_raw),
    .ld_data  (ld_data)
  );

  assign base_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  // Memory-side outputs are held at zero outside the request states.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    if (mem_req) begin
      mem_we   = we_q;
      mem_addr = second_beat ? (base_addr + ADDR_W'(NB)) : base_addr;
      mem_be   = second_beat ? st_be[2*NB-1:NB] : st_be[NB-1:0];
      if (we_q) begin
        mem_wdata = second_beat ? st_wdata[2*XLEN-1:XLEN] : st_wdata[XLEN-1:0];
      end
    end
  end

  assign req_ready = out_en && (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign rsp_rdata = rsp_valid ? rdata_q : '0;
  assign rsp_err   = rsp_valid && err_q;

  // out_en keeps req_ready low until the first cycle after reset is released.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      out_en  <= 1'b0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
      split_q <= 1'b0;
      beat1_q <= '0;
`endif
    end else begin
      out_en <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef LSU_MISALIGNED_SPLIT_EN
            split_q <= req_misal && req_cross;
`endif
            if (!req_legal || (req_misal && !SPLIT_EN)) begin
              err_q <= 1'b1;
              state <= ST_RESP;
            end else begin
              state <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (mem_gnt) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
            if (split_q && !mem_err) begin
              beat1_q <= mem_rdata;
              state   <= ST_REQ2;
            end else
`endif
            begin
              err_q   <= mem_err;
              rdata_q <= (mem_err || we_q) ? '0 : ld_data;
              state   <= ST_RESP;
            end
          end
        end
`ifdef LSU_MISALIGNED_SPLIT_EN
        ST_REQ2: begin
          if (mem_gnt) state <= ST_WAIT2;
        end
        ST_WAIT2: begin
          if (mem_rvalid) begin
            err_q   <= mem_err;
            rdata_q <= (mem_err || we_q) ? '0 : ld_data;
            state   <= ST_RESP;
          end
        end
`endif
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
